// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding and byte width for the UART transmit path
package uart_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACCEPT, WAIT_FRAME} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority selector, first set req after last wins
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);
  logic [W-1:0] idx;
  // Scan from the farthest slot back to last+1 so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    winner = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) begin
        valid = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with an accept watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ACCEPT_TIMEOUT = 64,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      active,
  output logic                      err_timeout
);
  localparam int TW = $clog2(ACCEPT_TIMEOUT) + 1;
  state_t state, state_n;
  logic [IDX_W-1:0] last, last_n, owner_n, win;
  logic [TW-1:0] timer, timer_n;
  logic [NUM_REQ-1:0] ack_n;
  logic [BYTE_W-1:0] data_n;
  logic start_n, err_n, valid;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req),
    .last(last),
    .valid(valid),
    .winner(win)
  );
  always_comb begin
    state_n = state;
    ack_n = '0;
    start_n = 1'b0;
    err_n = 1'b0;
    owner_n = owner;
    data_n = tx_data;
    last_n = last;
    timer_n = timer;
    case (state)
      IDLE: if (valid && !tx_busy) begin
        state_n = LAUNCH;
        start_n = 1'b1;
        owner_n = win;
        data_n = req_data[BYTE_W*win +: BYTE_W];
      end
      LAUNCH: begin
        state_n = WAIT_ACCEPT;
        timer_n = '0;
      end
      WAIT_ACCEPT: begin
        // An accept on the expiry cycle still wins over the timeout.
        if (tx_busy) begin
          ack_n[owner] = 1'b1;
          last_n = owner;
          state_n = WAIT_FRAME;
        end else if (timer == TW'(ACCEPT_TIMEOUT - 1)) begin
          err_n = 1'b1;
          last_n = owner;
          state_n = IDLE;
        end else begin
          timer_n = &timer ? timer : timer + 1'b1;
        end
      end
      WAIT_FRAME: state_n = tx_busy ? WAIT_FRAME : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack <= '0;
      tx_start <= 1'b0;
      tx_data <= '0;
      owner <= '0;
      active <= 1'b0;
      err_timeout <= 1'b0;
      last <= IDX_W'(NUM_REQ - 1);
      timer <= '0;
    end else begin
      state <= state_n;
      ack <= ack_n;
      tx_start <= start_n;
      tx_data <= data_n;
      owner <= owner_n;
      active <= state_n != IDLE;
      err_timeout <= err_n;
      last <= last_n;
      timer <= timer_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors plus cycle-level corner sequences for the arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1, tx_busy = 1'b0;
  logic [3:0] req = '0, ack;
  logic [31:0] req_data = '0;
  logic tx_start, active, err_timeout;
  logic [7:0] tx_data;
  logic [1:0] owner;
  int checks = 0, failures = 0, mon_bad = 0;
  int dly = 2, pend = 0, hold = 0;
  uart_tx_arbiter #(.NUM_REQ(4), .ACCEPT_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .owner(owner),
    .active(active), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  // Transmitter model: busy rises dly cycles after tx_start (never if dly==0), stays high 20 cycles.
  always @(posedge clk) begin
    if (tx_start && dly > 0) pend <= dly - 1;
    else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        tx_busy <= 1'b1;
        hold <= 20;
      end
    end else if (tx_busy) begin
      hold <= hold - 1;
      if (hold == 1) tx_busy <= 1'b0;
    end
  end
  always @(negedge clk) if (!rst && ($countones(ack) > 1 || (|ack && err_timeout))) mon_bad++;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          dly;
    int          own;
    logic [7:0]  byt;
    logic [3:0]  ack;
    logic        err;
    int          lat;
  } vec_t;
  vec_t tv[9];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 100);
    check("start_seen", tx_start, 1);
  endtask
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 0 && !err_timeout && n < 100);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((active || tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", active, 0);
  endtask
  initial begin
    int n, bad;
    // Latency counts negedges from the tx_start cycle to the ack/err cycle.
    tv[0] = '{4'b1111, 32'h13121110, 2,  0, 8'h10, 4'b0001, 1'b0, 3};
    tv[1] = '{4'b1111, 32'h13121110, 2,  1, 8'h11, 4'b0010, 1'b0, 3};
    tv[2] = '{4'b1111, 32'h13121110, 2,  2, 8'h12, 4'b0100, 1'b0, 3};
    tv[3] = '{4'b1111, 32'h13121110, 2,  3, 8'h13, 4'b1000, 1'b0, 3};
    tv[4] = '{4'b1111, 32'h13121110, 2,  0, 8'h10, 4'b0001, 1'b0, 3};
    tv[5] = '{4'b0100, 32'h005A0000, 2,  2, 8'h5A, 4'b0100, 1'b0, 3};
    tv[6] = '{4'b0011, 32'h0000BBAA, 0,  0, 8'hAA, 4'b0000, 1'b1, 17};
    tv[7] = '{4'b0011, 32'h0000BBAA, 2,  1, 8'hBB, 4'b0010, 1'b0, 3};
    tv[8] = '{4'b0001, 32'h00000077, 16, 0, 8'h77, 4'b0001, 1'b0, 17};
    repeat (3) @(negedge clk);
    check("reset_outputs", {ack, tx_start, tx_data, owner, active, err_timeout}, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      req = tv[i].req;
      req_data = tv[i].data;
      dly = tv[i].dly;
      wait_start(n);
      check("vec_owner", owner, tv[i].own);
      check("vec_tx_data", tx_data, tv[i].byt);
      wait_ack(n);
      check("vec_ack", ack, tv[i].ack);
      check("vec_err", err_timeout, tv[i].err);
      check("vec_latency", n, tv[i].lat);
    end
    req = '0;
    dly = 2;
    wait_idle();
    req = 4'b0100;
    req_data = 32'h005A0000;
    wait_start(n);
    check("single_start_latency", n, 1);
    check("single_owner", owner, 2);
    check("single_tx_data", tx_data, 8'h5A);
    @(negedge clk);
    check("single_start_pulse", tx_start, 0);
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("single_ack", ack, 4'b0100);
    req = '0;
    @(negedge clk);
    check("single_ack_pulse", ack, 0);
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("single_active_at_fall", active, 1);
    @(negedge clk);
    check("single_active_after", active, 0);
    req = 4'b1000;
    req_data = 32'hC3000000;
    wait_start(n);
    check("stable_owner", owner, 3);
    check("stable_tx_data", tx_data, 8'hC3);
    req_data = 32'hFFFFFFFF;
    req = '0;
    bad = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (tx_data != 8'hC3) bad++;
    end while (ack == 0 && n < 100);
    check("stable_ack", ack, 4'b1000);
    n = 0;
    while (active && n < 100) begin
      @(negedge clk);
      n++;
      if (active && tx_data != 8'hC3) bad++;
    end
    check("stable_hold", bad, 0);
    wait_idle();
    req = 4'b0010;
    wait_start(n);
    check("rst_pre_owner", owner, 1);
    wait_ack(n);
    check("rst_pre_ack", ack, 4'b0010);
    req = 4'b1001;
    req_data = 32'h99000088;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {ack, tx_start, tx_data, owner, active, err_timeout}, 0);
    rst = 1'b0;
    bad = 0;
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
      if (active || tx_start) bad++;
    end
    check("rst_idle_while_busy", bad, 0);
    wait_start(n);
    check("rst_grant_latency", n, 1);
    check("rst_owner", owner, 0);
    check("rst_tx_data", tx_data, 8'h88);
    wait_ack(n);
    check("rst_ack", ack, 4'b0001);
    req = '0;
    wait_idle();
    check("ack_onehot_no_err_overlap", mon_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
